pulse_stretcher: RTL and testbench

- Converts single-cycle request strobes into clean level pulses. Each request produces exactly one high period of fixed width, followed by a guaranteed low gap.
- Feeds slow or level-sensitive consumers: LEDs, external pins, and any downstream rising-edge detector, which must see one distinct edge per request.
- Requests that arrive while a pulse is in progress are counted and replayed in order.

---
 rtl/pulse_stretcher.sv | 140 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle request strobes into fixed-width high pulses separated by
// a guaranteed low gap; requests arriving mid-pulse are counted and replayed in order.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic              clear_overflow,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;

    logic               phase_done;
    logic               dequeue;
    logic               direct_start;
    logic               drop;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        phase_done   = (cnt_q == '0);
        dequeue      = 1'b0;
        direct_start = 1'b0;
        drop         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (phase_done) begin
                    state_d = ST_LOW;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_done) begin
                    if (pend_q != '0) begin
                        dequeue = 1'b1;
                        state_d = ST_HIGH;
                        cnt_d   = HIGH_LOAD;
                    end else if (trigger) begin
                        direct_start = 1'b1;
                        state_d      = ST_HIGH;
                        cnt_d        = HIGH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A trigger on the dequeue cycle replaces the request being started, so the count holds.
        if (trigger && (state_q != ST_IDLE) && !direct_start) begin
            if (!dequeue) begin
                if (pend_q == PEND_MAX) begin
                    drop = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
        end else if (dequeue) begin
            pend_d = pend_q - 1'b1;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end

        out_d  = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed and randomized bench for pulse_stretcher; a time-schedule reference model
// predicts every output each cycle, and an observer checks pulse widths and gaps.
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int L    = 4;
    localparam int PW   = 3;
    localparam int MAXP = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger;
    logic          clear_overflow;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .PEND_W     (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trigger       (trigger),
        .clear_overflow(clear_overflow),
        .out           (out),
        .busy          (busy),
        .pending       (pending),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the current pulse is described by the cycle its high period starts.
    int t = 0;
    bit m_active = 1'b0;
    int m_start = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;
    int accepted = 0;

    // Observer state
    bit prev_out = 1'b0;
    int run_len = 0;
    int gap_len = 0;
    int pulses_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic bit m_out();
        return m_active && (t >= m_start) && (t <= m_start + H - 1);
    endfunction

    task automatic model_step(input bit trig, input bit clr);
        bit last;
        bit drop;
        int p0;
        drop = 1'b0;
        p0   = m_pend;
        if (!m_active) begin
            if (trig) begin
                m_active = 1'b1;
                m_start  = t + 1;
                accepted++;
            end
        end else begin
            last = (t == m_start + H + L - 1);
            if (last) begin
                if (p0 > 0) begin
                    m_start = t + 1;
                    m_pend  = p0 - 1 + (trig ? 1 : 0);
                end else if (trig) begin
                    m_start = t + 1;
                end else begin
                    m_active = 1'b0;
                end
                if (trig) accepted++;
            end else if (trig) begin
                if (p0 == MAXP) drop = 1'b1;
                else begin
                    m_pend++;
                    accepted++;
                end
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        t++;
    endtask

    task automatic observe();
        if (out === 1'b1) begin
            if (!prev_out) begin
                if (pulses_seen > 0) check("gap_ge_low", 32'(gap_len >= L), 32'd1);
                pulses_seen++;
                run_len = 1;
            end else begin
                run_len++;
            end
        end else begin
            if (prev_out) begin
                check("pulse_width", run_len, H);
                gap_len = 1;
            end else begin
                gap_len++;
            end
        end
        prev_out = (out === 1'b1);
    endtask

    task automatic cycle(input bit trig, input bit clr);
        trigger        = trig;
        clear_overflow = clr;
        @(posedge clk);
        model_step(trig, clr);
        #1;
        check("out", out, m_out());
        check("busy", busy, m_active);
        check("pending", pending, m_pend);
        check("overflow", overflow, m_ovf);
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic clear_counters();
        accepted    = 0;
        pulses_seen = 0;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pend   = 0;
        m_ovf    = 1'b0;
        prev_out = 1'b0;
        run_len  = 0;
        gap_len  = 0;
        clear_counters();
    endtask

    initial begin
        rst            = 1'b1;
        trigger        = 1'b0;
        clear_overflow = 1'b0;
        #1;
        check("reset_out", out, 0);
        check("reset_busy", busy, 0);
        check("reset_pending", pending, 0);
        check("reset_overflow", overflow, 0);
        @(posedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1;
        check("trigger_ignored_in_reset", out, 0);
        rst     = 1'b0;
        trigger = 1'b0;
        model_reset();
        idle(3);

        // Single request
        clear_counters();
        cycle(1'b1, 1'b0);
        check("single_latency", out, 1);
        idle(20);
        check("single_pulse_count", pulses_seen, 1);

        // Burst of three
        clear_counters();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("burst_pending", pending, 2);
        idle(30);
        check("burst_pulse_count", pulses_seen, 3);

        // Boundary trigger on last LOW cycle
        clear_counters();
        cycle(1'b1, 1'b0);
        idle(H + L - 1);
        cycle(1'b1, 1'b0);
        check("boundary_out", out, 1);
        check("boundary_busy", busy, 1);
        check("boundary_pending", pending, 0);
        idle(20);
        check("boundary_pulse_count", pulses_seen, 2);

        // Overflow: 12 consecutive triggers, 9 accepted (one on the dequeue cycle)
        clear_counters();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_pending_sat", pending, MAXP);
        idle(90);
        check("ovf_pulse_count", pulses_seen, 9);
        check("ovf_sticky", overflow, 1);

        // Clear alone, then clear colliding with a drop
        cycle(1'b0, 1'b1);
        check("ovf_cleared", overflow, 0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        check("ovf_cleared_full", overflow, 0);
        cycle(1'b1, 1'b1);
        check("ovf_set_wins", overflow, 1);
        idle(90);

        // Async reset mid-HIGH with three queued
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("pre_reset_pending", pending, 3);
        check("pre_reset_out", out, 1);
        #2 rst = 1'b1;
        #1;
        check("async_out", out, 0);
        check("async_busy", busy, 0);
        check("async_pending", pending, 0);
        check("async_overflow", overflow, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(30);
        check("no_replay_after_reset", pulses_seen, 0);

        // Randomized traffic at several request densities
        clear_counters();
        for (int seg = 0; seg < 4; seg++) begin
            int pct;
            pct = (seg == 0) ? 10 : (seg == 1) ? 35 : (seg == 2) ? 90 : 55;
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(0, 99) < pct, $urandom_range(0, 99) < 3);
        end
        idle(100);
        check("random_idle_busy", busy, 0);
        check("random_accounting", pulses_seen, accepted);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
